// File: rtl/count_display_driver.sv
// Display-side consumer of the two-phase counter: holds the last pre-finish count,
// tallies completed runs in saturating BCD, flags a frozen counter and drives a 2-digit 7-segment display.
module count_display_driver #(
    parameter int unsigned REFRESH_DIV = 4,
    parameter int unsigned STALL_CYC   = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] count_in,
    input  logic       finish_in,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       done_pulse,
    output logic [7:0] run_bcd,
    output logic       stalled
);

    typedef enum logic {
        DIGIT0 = 1'b0,
        DIGIT1 = 1'b1
    } digit_t;

    localparam logic [15:0] REF_LAST  = 16'(REFRESH_DIV - 1);
    localparam logic [15:0] STALL_MAX = 16'(STALL_CYC);

    logic [3:0]  count_q;
    logic [3:0]  count_prev;
    logic        finish_q;
    logic        finish_d;
    logic [3:0]  hold_val;
    logic [15:0] ref_cnt;
    logic [15:0] stall_cnt;
    digit_t      sel;

    logic        finish_rise;
    logic [7:0]  run_next;
    logic [15:0] ref_next;
    digit_t      sel_next;
    logic [15:0] stall_next;
    logic [3:0]  shown_val;
    logic [6:0]  seg_next;
    logic [1:0]  an_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign finish_rise = finish_q & ~finish_d;

    // Saturating two-digit BCD increment, applied on the same edge that raises done_pulse.
    always_comb begin
        run_next = run_bcd;
        if (finish_rise && run_bcd != 8'h99) begin
            if (run_bcd[3:0] == 4'd9) begin
                run_next = {run_bcd[7:4] + 4'd1, 4'd0};
            end else begin
                run_next = {run_bcd[7:4], run_bcd[3:0] + 4'd1};
            end
        end
    end

    always_comb begin
        ref_next = ref_cnt + 16'd1;
        sel_next = sel;
        if (ref_cnt >= REF_LAST) begin
            ref_next = 16'd0;
            sel_next = (sel == DIGIT0) ? DIGIT1 : DIGIT0;
        end
    end

    // The stall tally restarts whenever the count moves or the counter reports finished.
    always_comb begin
        stall_next = stall_cnt;
        if (finish_q || count_q != count_prev) begin
            stall_next = 16'd0;
        end else if (stall_cnt < STALL_MAX) begin
            stall_next = stall_cnt + 16'd1;
        end
    end

    // seg and an are computed from the upcoming select so both flip on the same edge.
    always_comb begin
        shown_val = hold_val;
        an_next   = 2'b10;
        if (sel_next == DIGIT1) begin
            shown_val = run_bcd[3:0];
            an_next   = 2'b01;
        end
        seg_next = seg_decode(shown_val);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= 4'd0;
            count_prev <= 4'd0;
            finish_q   <= 1'b0;
            finish_d   <= 1'b0;
            hold_val   <= 4'd0;
            done_pulse <= 1'b0;
            run_bcd    <= 8'h00;
            ref_cnt    <= 16'd0;
            sel        <= DIGIT0;
            stall_cnt  <= 16'd0;
            stalled    <= 1'b0;
            seg        <= 7'b1111111;
            an         <= 2'b10;
        end else begin
            count_q    <= count_in;
            count_prev <= count_q;
            finish_q   <= finish_in;
            finish_d   <= finish_q;
            if (!finish_q) begin
                hold_val <= count_q;
            end
            done_pulse <= finish_rise;
            run_bcd    <= run_next;
            ref_cnt    <= ref_next;
            sel        <= sel_next;
            stall_cnt  <= stall_next;
            stalled    <= (stall_next == STALL_MAX) & ~finish_q;
            seg        <= seg_next;
            an         <= an_next;
        end
    end

endmodule

// File: doc/count_display_driver.md
Name: count_display_driver

Overview:
- Downstream consumer of the two-phase counter's 4-bit value and `finish` flag.
- Registers the count, holds the last valid value once `finish` is asserted, and counts completed runs in BCD (saturating).
- Flags a stalled counter and drives a 2-digit multiplexed active-low 7-segment display: digit0 shows the held count in hex, digit1 shows the run-count units.
- Single clock domain, same clock as the counter's fast clock.

Parameters:
- REFRESH_DIV, 4, clock cycles each digit stays active (legal 2..65535).
- STALL_CYC, 64, consecutive unchanged-count cycles (finish low) before `stalled` asserts (legal 2..65535).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- count_in  input  4  counter value (0..15).
- finish_in  input  1  counter-complete level.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- an  output  2  digit enables, active-low one-hot, registered; an[0] = digit0.
- done_pulse  output  1  one-cycle pulse per finish rising edge.
- run_bcd  output  8  completed runs, {tens, units} BCD, 0..99 saturating.
- stalled  output  1  count frozen while not finished.

Behaviour:
- Reset (rst=1 at a clock edge) values: seg=7'b1111111, an=2'b10, done_pulse=0, run_bcd=8'h00, stalled=0. Internal registers also clear: count_q, finish_q, finish_d, hold_val, refresh counter, active-digit select (digit0), stall counter. Reset overrides all other activity, including mid-run.
- Input stage: count_q<=count_in and finish_q<=finish_in every cycle; finish_d<=finish_q.
- Hold register: hold_val<=count_q when finish_q==0; unchanged when finish_q==1. This retains the last pre-finish value even though the counter's output forces 0 when finished.
- Edge detect: done_pulse<=finish_q & ~finish_d. Latency: finish_in rising at edge N gives finish_q=1 after N and done_pulse=1 after N+1, for exactly one cycle. A held-high finish produces no further pulses.
- Run counter: increments in the cycle done_pulse is set.
  - BCD: units 9 wraps to 0 with tens+1.
  - At 8'h99 it holds (saturates).
  - Only rst clears it.
- Refresh: counter runs 0..REFRESH_DIV-1. At terminal count it returns to 0 and the active-digit select toggles. an reflects the select: digit0 gives 2'b10, digit1 gives 2'b01. Exactly one digit is enabled at all times after reset.
- Segment register: seg<=decode(hold_val) when digit0 is active, decode(run_bcd[3:0]) when digit1 is active. It is updated in the same cycle as an, so seg and an always change together.
- Decode (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Count-to-display latency: count_in at edge N, count_q at N, hold_val at N+1, seg at N+2 (digit0 active).
- Stall detection: the stall counter clears whenever count_q changes from its previous value or finish_q==1. Otherwise it increments and saturates at STALL_CYC. stalled = (counter==STALL_CYC) & ~finish_q, registered. stalled deasserts the cycle after count_q changes or finish_q rises.
- Wrap-around: hold_val is displayed as a full 4-bit hex digit, so count_in values 10..15 show A..F.
- Simultaneous finish rise and count change: hold_val keeps the pre-finish value; done_pulse fires; stall counter clears.

Test Plan:
- Reset: hold rst=1 for 3 cycles → seg=7F, an=2'b10, run_bcd=00, done_pulse=0, stalled=0; after release (REFRESH_DIV=4), an toggles every 4 cycles.
- Hold: drive count_in 0→9 then 0 with finish_in=1 simultaneously → digit0 seg settles to 0010000 ("9"), not 1000000; done_pulse high exactly one cycle, two edges after the finish_in rise.
- Run counting: 12 finish pulses, finish_in low between them → run_bcd=8'h12; digit1 seg shows 0100100 ("2").
- Saturation: 105 finish pulses → run_bcd stays 8'h99; a further pulse still produces done_pulse but run_bcd remains 99.
- Stall: STALL_CYC=64, count_in fixed at 5 with finish_in=0 → stalled rises after 64 unchanged cycles (±1 for the register stage); changing count_in to 6 clears it next cycle; finish_in=1 with a fixed count never asserts stalled.
- Mid-operation reset: assert rst with run_bcd=8'h07 and digit1 active → next cycle all outputs at reset values; digit0 displays 0 after release.
